// File: rtl/fmul_issue_if.sv
// Request/result handshake bundle for fmul_issue: dispatch-side requests and
// writeback-side results share one interface.
interface fmul_issue_if #(
  parameter int TAG_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_x1;
  logic [31:0]      req_x2;
  logic [TAG_W-1:0] req_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_y;
  logic [TAG_W-1:0] res_tag;

  modport master (
    output req_valid, req_x1, req_x2, req_tag, res_ready,
    input  req_ready, res_valid, res_y, res_tag
  );

  modport slave (
    input  req_valid, req_x1, req_x2, req_tag, res_ready,
    output req_ready, res_valid, res_y, res_tag
  );
endinterface

// File: rtl/fmul_issue.sv
// Issue stage around the stall-free 2-cycle fmul pipeline: tags ride a shadow
// pipeline and products land in an in-order result FIFO guarded by credits.
module fmul_issue #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fmul_issue_if.slave io,
  output logic [31:0] mul_x1,
  output logic [31:0] mul_x2,
  input  logic [31:0] mul_y,
  output logic        idle
);
  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int CRD_W  = OCC_W + 1;

  logic              fire, push, pop;
  logic              vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [TAG_W-1:0]  tag_p1_d, tag_p1_q, tag_p2_d, tag_p2_q;
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [OCC_W-1:0]  occ_d, occ_q;
  logic [CRD_W-1:0]  credit;
  logic [DATA_W-1:0] mem_y   [DEPTH];
  logic [TAG_W-1:0]  mem_tag [DEPTH];

  // Credit counts in-flight requests as already occupying FIFO slots, so a
  // push can never find the FIFO full; pops are only credited next cycle.
  assign credit       = {1'b0, occ_q} + CRD_W'(vld_p1_q) + CRD_W'(vld_p2_q);
  assign io.req_ready = !rst && (credit < CRD_W'(DEPTH));
  assign fire         = io.req_valid && io.req_ready;

  assign mul_x1 = fire ? io.req_x1 : '0;
  assign mul_x2 = fire ? io.req_x2 : '0;

  assign io.res_valid = (occ_q != '0);
  assign io.res_y     = io.res_valid ? mem_y[rd_ptr_q]   : '0;
  assign io.res_tag   = io.res_valid ? mem_tag[rd_ptr_q] : '0;
  assign idle         = !vld_p1_q && !vld_p2_q && (occ_q == '0);

  assign push = vld_p2_q;
  assign pop  = io.res_valid && io.res_ready;

  always_comb begin
    vld_p1_d = fire;
    tag_p1_d = io.req_tag;
    vld_p2_d = vld_p1_q;
    tag_p2_d = tag_p1_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Stage boundary p1/p2: control state, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Stage boundary p1/p2 data and FIFO storage: qualified by the valids above.
  always_ff @(posedge clk) begin
    tag_p1_q <= tag_p1_d;
    tag_p2_q <= tag_p2_d;
    if (push) begin
      mem_y[wr_ptr_q]   <= mul_y;
      mem_tag[wr_ptr_q] <= tag_p2_q;
    end
  end
endmodule

// File: tb/tb_fmul_issue.sv
// Directed bench for fmul_issue with a behavioural 2-stage fmul stand-in.
module tb_fmul_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mul_x1, mul_x2, mul_y;
  logic [31:0] s1, s2;
  logic        idle;
  int          total = 0;
  int          bad   = 0;
  int          k;
  logic        fired;
  logic [13:0] rdy_tab;
  logic [31:0] st_y [4];

  always #5 clk = ~clk;

  fmul_issue_if #(.TAG_W(6)) bus ();

  fmul_issue #(.TAG_W(6), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io     (bus.slave),
    .mul_x1 (mul_x1),
    .mul_x2 (mul_x2),
    .mul_y  (mul_y),
    .idle   (idle)
  );

  // Known products only; 1.0 times x is x, zero operands give signed zero.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) r = {a[31] ^ b[31], 31'd0};
    else if (a == 32'h3F80_0000) r = b;
    else begin
      case ({a, b})
        64'h40000000_40400000: r = 32'h40C0_0000;
        64'h3FC00000_3FC00000: r = 32'h4010_0000;
        64'hC0000000_40400000: r = 32'hC0C0_0000;
        64'h7F000000_7F000000: r = 32'h7F80_0000;
        default:               r = 32'hDEAD_BEEF;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    s1 <= fmul_ref(mul_x1, mul_x2);
    s2 <= s1;
  end
  assign mul_y = s2;

  always @(negedge clk) begin
    if (rst === 1'b0 && dut.vld_p2_q && dut.occ_q == 3'd4) begin
      bad++;
      $error("FAIL overflow: push into full fifo occ=%0d", dut.occ_q);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] t);
    bus.req_valid = v;
    bus.req_x1    = a;
    bus.req_x2    = b;
    bus.req_tag   = t;
  endtask

  initial begin
    rst = 1'b1;
    bus.res_ready = 1'b0;
    req(1'b1, 32'h4000_0000, 32'h4040_0000, 6'd7);
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_y", bus.res_y, 32'd0);
    chk("rst_res_tag", bus.res_tag, 6'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_mul_x1", mul_x1, 32'd0);
    chk("rst_mul_x2", mul_x2, 32'd0);
    nxt();
    rst = 1'b0;
    req(1'b0, 32'd0, 32'd0, 6'd0);
    @(negedge clk);
    chk("post_rst_ready", bus.req_ready, 1'b1);
    nxt();

    // Single op
    req(1'b1, 32'h4000_0000, 32'h4040_0000, 6'd5);
    @(negedge clk);
    chk("s_c0_ready", bus.req_ready, 1'b1);
    chk("s_c0_mul_x1", mul_x1, 32'h4000_0000);
    chk("s_c0_mul_x2", mul_x2, 32'h4040_0000);
    nxt();
    req(1'b0, 32'h1234_5678, 32'h1234_5678, 6'd0);
    @(negedge clk);
    chk("s_c1_idle", idle, 1'b0);
    chk("s_c1_valid", bus.res_valid, 1'b0);
    chk("s_c1_mul_x1_gated", mul_x1, 32'd0);
    nxt();
    @(negedge clk);
    chk("s_c2_idle", idle, 1'b0);
    chk("s_c2_valid", bus.res_valid, 1'b0);
    nxt();
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("s_c3_valid", bus.res_valid, 1'b1);
    chk("s_c3_y", bus.res_y, 32'h40C0_0000);
    chk("s_c3_tag", bus.res_tag, 6'd5);
    chk("s_c3_idle", idle, 1'b0);
    nxt();
    @(negedge clk);
    chk("s_c4_valid", bus.res_valid, 1'b0);
    chk("s_c4_y", bus.res_y, 32'd0);
    chk("s_c4_idle", idle, 1'b1);
    nxt();

    // Back-to-back stream
    st_y[0] = 32'h4010_0000;
    st_y[1] = 32'hC0C0_0000;
    st_y[2] = 32'h0000_0000;
    st_y[3] = 32'h7F80_0000;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: req(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 6'd1);
        1: req(1'b1, 32'hC000_0000, 32'h4040_0000, 6'd2);
        2: req(1'b1, 32'h0000_0000, 32'h4040_0000, 6'd3);
        3: req(1'b1, 32'h7F00_0000, 32'h7F00_0000, 6'd4);
        default: req(1'b0, 32'd0, 32'd0, 6'd0);
      endcase
      @(negedge clk);
      if (c < 4) chk($sformatf("b2b_ready_c%0d", c), bus.req_ready, 1'b1);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("b2b_valid_c%0d", c), bus.res_valid, 1'b1);
        chk($sformatf("b2b_y_c%0d", c), bus.res_y, st_y[c-3]);
        chk($sformatf("b2b_tag_c%0d", c), bus.res_tag, 6'(c - 2));
      end
      if (c == 7) chk("b2b_empty", bus.res_valid, 1'b0);
      nxt();
    end

    // Backpressure: tags 0..5 offered with res_ready low until cycle 8
    rdy_tab = 14'b11111_00000_1111;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      bus.res_ready = (c >= 8);
      req(k < 6, 32'h3F80_0000, 32'h4000_0000 + (k << 16), 6'(k));
      @(negedge clk);
      chk($sformatf("bp_ready_c%0d", c), bus.req_ready, rdy_tab[c]);
      fired = bus.req_valid && bus.req_ready;
      if (c == 7) begin
        chk("bp_hold_valid", bus.res_valid, 1'b1);
        chk("bp_hold_tag", bus.res_tag, 6'd0);
      end
      if (c >= 8) begin
        chk($sformatf("bp_valid_c%0d", c), bus.res_valid, 1'b1);
        chk($sformatf("bp_tag_c%0d", c), bus.res_tag, 6'(c - 8));
        chk($sformatf("bp_y_c%0d", c), bus.res_y, 32'h4000_0000 + ((c - 8) << 16));
      end
      nxt();
      if (fired) k++;
    end
    req(1'b0, 32'd0, 32'd0, 6'd0);
    @(negedge clk);
    chk("bp_accepted", k, 6);
    chk("bp_drained", bus.res_valid, 1'b0);
    chk("bp_idle", idle, 1'b1);
    nxt();

    // Push and pop together at occ=3 across the pointer wrap
    for (int c = 0; c < 12; c++) begin
      bus.res_ready = (c >= 7);
      case (c)
        0: req(1'b1, 32'h3F80_0000, 32'h4100_0000 + (10 << 12), 6'd10);
        1: req(1'b1, 32'h3F80_0000, 32'h4100_0000 + (11 << 12), 6'd11);
        2: req(1'b1, 32'h3F80_0000, 32'h4100_0000 + (12 << 12), 6'd12);
        5: req(1'b1, 32'h3F80_0000, 32'h4100_0000 + (13 << 12), 6'd13);
        default: req(1'b0, 32'd0, 32'd0, 6'd0);
      endcase
      @(negedge clk);
      if (bus.req_valid) chk($sformatf("wr_ready_c%0d", c), bus.req_ready, 1'b1);
      if (c == 5) chk("wr_occ_c5", dut.occ_q, 3'd3);
      if (c == 7 || c == 8) chk($sformatf("wr_occ_c%0d", c), dut.occ_q, 3'd3);
      if (c == 8) chk("wr_rd_ptr_wrapped", dut.rd_ptr_q, 2'd0);
      if (c >= 7 && c <= 10) begin
        chk($sformatf("wr_tag_c%0d", c), bus.res_tag, 6'(c + 3));
        chk($sformatf("wr_y_c%0d", c), bus.res_y, 32'h4100_0000 + ((c + 3) << 12));
      end
      if (c == 11) chk("wr_empty", bus.res_valid, 1'b0);
      nxt();
    end

    // Reset mid-operation
    bus.res_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      case (c)
        0: req(1'b1, 32'h3F80_0000, 32'h4050_0000, 6'd20);
        1: req(1'b1, 32'h3F80_0000, 32'h4060_0000, 6'd21);
        9: req(1'b1, 32'h3F80_0000, 32'h4120_0000, 6'd30);
        default: req(1'b0, 32'd0, 32'd0, 6'd0);
      endcase
      rst = (c == 2);
      @(negedge clk);
      if (c == 2) begin
        chk("mr_rst_ready", bus.req_ready, 1'b0);
        chk("mr_rst_idle", idle, 1'b1);
      end
      if (c >= 2 && c <= 11) chk($sformatf("mr_novalid_c%0d", c), bus.res_valid, 1'b0);
      if (c >= 3 && c <= 8) chk($sformatf("mr_idle_c%0d", c), idle, 1'b1);
      if (c == 9) chk("mr_ready_c9", bus.req_ready, 1'b1);
      if (c == 12) begin
        chk("mr_valid", bus.res_valid, 1'b1);
        chk("mr_tag", bus.res_tag, 6'd30);
        chk("mr_y", bus.res_y, 32'h4120_0000);
      end
      nxt();
    end

    // Empty pop: consumer ready with nothing buffered
    req(1'b0, 32'd0, 32'd0, 6'd0);
    bus.res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("ep_state_c%0d", c), {dut.occ_q, dut.rd_ptr_q, dut.wr_ptr_q}, {3'd0, 2'd1, 2'd1});
      chk($sformatf("ep_valid_c%0d", c), bus.res_valid, 1'b0);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
